mem_initiator: RTL

MEM_INITIATOR -- requirements
Module: mem_initiator

---
 rtl/mem_initiator.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/mem_initiator.sv
// +----------------------------------------------------------------------------+
// | mem_initiator                                                              |
// | Burst memory initiator: turns one command into cmd_len+1 single-beat       |
// | memory accesses. Optional WAIT timeout enabled by MEM_INIT_TIMEOUT_EN.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module mem_initiator #(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 32,
    parameter int LEN_WIDTH      = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_last,
    output logic                  rsp_err,
    input  logic                  rsp_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_wren,
    output logic                  mem_rden,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_valid,
    output logic                  busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]            state_q,     state_d;
    logic                  write_q,     write_d;
    logic [ADDR_WIDTH-1:0] base_addr_q, base_addr_d;
    logic [DATA_WIDTH-1:0] seed_q,      seed_d;
    logic [LEN_WIDTH-1:0]  len_q,       len_d;
    logic [LEN_WIDTH-1:0]  beat_q,      beat_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                  mem_wren_q,  mem_wren_d;
    logic                  mem_rden_q,  mem_rden_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_data_q,  rsp_data_d;
    logic                  rsp_last_q,  rsp_last_d;
    logic                  cmd_ready_q, busy_q;

    logic [LEN_WIDTH-1:0]  beat_nxt;
    logic                  beat_is_last;

`ifdef MEM_INIT_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          rsp_err_q, rsp_err_d;
`endif

    assign beat_nxt     = beat_q + LEN_WIDTH'(1);
    assign beat_is_last = (beat_q == len_q);

    always_comb begin
        state_d     = state_q;
        write_d     = write_q;
        base_addr_d = base_addr_q;
        seed_d      = seed_q;
        len_d       = len_q;
        beat_d      = beat_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wren_d  = 1'b0;
        mem_rden_d  = 1'b0;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_last_d  = rsp_last_q;
`ifdef MEM_INIT_TIMEOUT_EN
        tmo_cnt_d   = tmo_cnt_q;
        rsp_err_d   = rsp_err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    write_d     = cmd_write;
                    base_addr_d = cmd_addr;
                    seed_d      = cmd_wdata;
                    len_d       = cmd_len;
                    beat_d      = '0;
                    mem_addr_d  = cmd_addr;
                    mem_wdata_d = cmd_wdata;
                    mem_wren_d  = cmd_write;
                    mem_rden_d  = ~cmd_write;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
`ifdef MEM_INIT_TIMEOUT_EN
                tmo_cnt_d = '0;
`endif
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (mem_valid) begin
                    if (!write_q) begin
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = mem_rdata;
                        rsp_last_d  = beat_is_last;
                        state_d     = S_RESP;
                    end else if (beat_is_last) begin
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = '0;
                        rsp_last_d  = 1'b1;
                        state_d     = S_RESP;
                    end else begin
                        // Intermediate write beats produce no response.
                        beat_d      = beat_nxt;
                        mem_addr_d  = base_addr_q + ADDR_WIDTH'(beat_nxt);
                        mem_wdata_d = seed_q + DATA_WIDTH'(beat_nxt);
                        mem_wren_d  = 1'b1;
                        state_d     = S_ISSUE;
                    end
                end
`ifdef MEM_INIT_TIMEOUT_EN
                else if (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = '0;
                    rsp_last_d  = 1'b1;
                    rsp_err_d   = 1'b1;
                    state_d     = S_RESP;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TW'(1);
                end
`endif
            end
            default: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_last_d  = 1'b0;
`ifdef MEM_INIT_TIMEOUT_EN
                    rsp_err_d   = 1'b0;
`endif
                    // rsp_last also covers an aborted burst.
                    if (rsp_last_q) begin
                        state_d = S_IDLE;
                    end else begin
                        beat_d      = beat_nxt;
                        mem_addr_d  = base_addr_q + ADDR_WIDTH'(beat_nxt);
                        mem_wdata_d = seed_q + DATA_WIDTH'(beat_nxt);
                        mem_wren_d  = write_q;
                        mem_rden_d  = ~write_q;
                        state_d     = S_ISSUE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            write_q     <= 1'b0;
            base_addr_q <= '0;
            seed_q      <= '0;
            len_q       <= '0;
            beat_q      <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wren_q  <= 1'b0;
            mem_rden_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_last_q  <= 1'b0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            write_q     <= write_d;
            base_addr_q <= base_addr_d;
            seed_q      <= seed_d;
            len_q       <= len_d;
            beat_q      <= beat_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wren_q  <= mem_wren_d;
            mem_rden_q  <= mem_rden_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_last_q  <= rsp_last_d;
            cmd_ready_q <= (state_d == S_IDLE);
            busy_q      <= (state_d != S_IDLE);
        end
    end

`ifdef MEM_INIT_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_cnt_q <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            rsp_err_q <= rsp_err_d;
        end
    end
    assign rsp_err = rsp_err_q;
`else
    assign rsp_err = 1'b0;
`endif

    assign cmd_ready = cmd_ready_q;
    assign busy      = busy_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wren  = mem_wren_q;
    assign mem_rden  = mem_rden_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_last  = rsp_last_q;

endmodule

`default_nettype wire
